// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter_if
// Description : Client-side request/response channels of the shared-ALU
//               arbiter. The slave modport is the arbiter; the master modport
//               is the pair of issuing clients.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);
  // Request channel, one per client
  logic             req_valid_0;
  logic             req_valid_1;
  logic             req_ready_0;
  logic             req_ready_1;
  logic [WIDTH-1:0] req_a_0;
  logic [WIDTH-1:0] req_a_1;
  logic [WIDTH-1:0] req_b_0;
  logic [WIDTH-1:0] req_b_1;
  logic [2:0]       req_op_0;
  logic [2:0]       req_op_1;

  // Response channel; result and flags are shared, valid/ready are per client
  logic             rsp_valid_0;
  logic             rsp_valid_1;
  logic             rsp_ready_0;
  logic             rsp_ready_1;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_overflow;

  modport slave (
    input  req_valid_0, req_valid_1,
    input  req_a_0, req_a_1, req_b_0, req_b_1, req_op_0, req_op_1,
    output req_ready_0, req_ready_1,
    output rsp_valid_0, rsp_valid_1,
    input  rsp_ready_0, rsp_ready_1,
    output rsp_result, rsp_zero, rsp_overflow
  );

  modport master (
    output req_valid_0, req_valid_1,
    output req_a_0, req_a_1, req_b_0, req_b_1, req_op_0, req_op_1,
    input  req_ready_0, req_ready_1,
    input  rsp_valid_0, rsp_valid_1,
    output rsp_ready_0, rsp_ready_1,
    input  rsp_result, rsp_zero, rsp_overflow
  );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin arbiter sharing one combinational ALU between two
//               clients. Operands are latched on grant, the ALU is driven for
//               one execute cycle, the result and flags are registered and held
//               until the owning client accepts the response.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  alu_share_arbiter_if.slave        clients,
  output logic [WIDTH-1:0]          alu_a,
  output logic [WIDTH-1:0]          alu_b,
  output logic [2:0]                alu_ctrl,
  input  wire logic [WIDTH-1:0]     alu_result,
  input  wire logic                 alu_zero,
  input  wire logic                 alu_overflow,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      done_cnt_0,
  output logic [CNT_WIDTH-1:0]      done_cnt_1
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_nextState;

  logic                 r_lastGrant;
  logic                 r_owner;
  logic [WIDTH-1:0]     r_opA;
  logic [WIDTH-1:0]     r_opB;
  logic [2:0]           r_opCtrl;
  logic [WIDTH-1:0]     r_rspResult;
  logic                 r_rspZero;
  logic                 r_rspOverflow;
  logic [CNT_WIDTH-1:0] r_doneCnt0;
  logic [CNT_WIDTH-1:0] r_doneCnt1;

  logic                 w_grant;
  logic                 w_anyValid;
  logic                 w_reqReady0;
  logic                 w_reqReady1;
  logic                 w_accept;
  logic                 w_rspHandshake;
  logic                 w_ownerReady;

  // Winner: a lone requester wins; on a tie the one not served last wins
  assign w_anyValid   = clients.req_valid_0 | clients.req_valid_1;
  assign w_grant      = (clients.req_valid_0 && clients.req_valid_1) ? ~r_lastGrant
                                                                     : clients.req_valid_1;
  assign w_ownerReady = r_owner ? clients.rsp_ready_1 : clients.rsp_ready_0;

  // Next-state and handshake decode
  always_comb begin
    w_nextState    = r_state;
    w_reqReady0    = 1'b0;
    w_reqReady1    = 1'b0;
    w_accept       = 1'b0;
    w_rspHandshake = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_anyValid) begin
          w_accept    = 1'b1;
          w_reqReady0 = ~w_grant;
          w_reqReady1 = w_grant;
          w_nextState = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_nextState = ST_RESP;
      end
      ST_RESP: begin
        // Non-owner rsp_ready is deliberately not looked at
        if (w_ownerReady) begin
          w_rspHandshake = 1'b1;
          w_nextState    = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State, operand, response and counter registers; reset overrides any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_lastGrant   <= 1'b1;
      r_owner       <= 1'b0;
      r_opA         <= '0;
      r_opB         <= '0;
      r_opCtrl      <= 3'b000;
      r_rspResult   <= '0;
      r_rspZero     <= 1'b0;
      r_rspOverflow <= 1'b0;
      r_doneCnt0    <= '0;
      r_doneCnt1    <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_owner  <= w_grant;
        r_opA    <= w_grant ? clients.req_a_1  : clients.req_a_0;
        r_opB    <= w_grant ? clients.req_b_1  : clients.req_b_0;
        r_opCtrl <= w_grant ? clients.req_op_1 : clients.req_op_0;
      end
      if (r_state == ST_EXEC) begin
        r_rspResult   <= alu_result;
        r_rspZero     <= alu_zero;
        r_rspOverflow <= alu_overflow;
      end
      if (w_rspHandshake) begin
        r_lastGrant <= r_owner;
        if (r_owner) begin
          r_doneCnt1 <= r_doneCnt1 + CNT_WIDTH'(1);
        end else begin
          r_doneCnt0 <= r_doneCnt0 + CNT_WIDTH'(1);
        end
      end
    end
  end

  // ALU is fed straight from the op registers so it holds outside EXEC
  assign alu_a    = r_opA;
  assign alu_b    = r_opB;
  assign alu_ctrl = r_opCtrl;

  assign clients.req_ready_0  = w_reqReady0;
  assign clients.req_ready_1  = w_reqReady1;
  assign clients.rsp_valid_0  = (r_state == ST_RESP) && !r_owner;
  assign clients.rsp_valid_1  = (r_state == ST_RESP) &&  r_owner;
  assign clients.rsp_result   = r_rspResult;
  assign clients.rsp_zero     = r_rspZero;
  assign clients.rsp_overflow = r_rspOverflow;

  assign busy       = (r_state != ST_IDLE);
  assign done_cnt_0 = r_doneCnt0;
  assign done_cnt_1 = r_doneCnt1;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Self-checking bench for alu_share_arbiter with a local
//               reference ALU attached to the shared ALU port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

  localparam int WIDTH     = 32;
  localparam int CNT_WIDTH = 16;

  logic                 clk;
  logic                 rst;
  logic [WIDTH-1:0]     alu_a;
  logic [WIDTH-1:0]     alu_b;
  logic [2:0]           alu_ctrl;
  logic [WIDTH-1:0]     alu_result;
  logic                 alu_zero;
  logic                 alu_overflow;
  logic                 busy;
  logic [CNT_WIDTH-1:0] done_cnt_0;
  logic [CNT_WIDTH-1:0] done_cnt_1;

  alu_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_share_arbiter #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .clients      (bus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .busy         (busy),
    .done_cnt_0   (done_cnt_0),
    .done_cnt_1   (done_cnt_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: add/sub with signed overflow, and, xor, slt; others give 0
  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      3'b000: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      3'b001: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a ^ alu_b;
      3'b101: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  int nPass  = 0;
  int nTotal = 0;
  int expCnt0 = 0;
  int expCnt1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        who;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] expRes;
    logic        expZero;
    logic        expOvf;
  } vec_t;

  vec_t vecs [8];

  task automatic clearInputs();
    bus.req_valid_0 = 1'b0;
    bus.req_valid_1 = 1'b0;
    bus.rsp_ready_0 = 1'b0;
    bus.rsp_ready_1 = 1'b0;
  endtask

  task automatic driveReq(input logic who, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op);
    if (!who) begin
      bus.req_valid_0 = 1'b1; bus.req_a_0 = a; bus.req_b_0 = b; bus.req_op_0 = op;
    end else begin
      bus.req_valid_1 = 1'b1; bus.req_a_1 = a; bus.req_b_1 = b; bus.req_op_1 = op;
    end
  endtask

  // One complete operation from IDLE, checking every phase
  task automatic runVec(input int i);
    vec_t v;
    v = vecs[i];
    driveReq(v.who, v.a, v.b, v.op);
    #1;
    check($sformatf("v%0d req_ready_0", i), {31'd0, bus.req_ready_0}, {31'd0, ~v.who});
    check($sformatf("v%0d req_ready_1", i), {31'd0, bus.req_ready_1}, {31'd0, v.who});
    step();
    bus.req_valid_0 = 1'b0;
    bus.req_valid_1 = 1'b0;
    #1;
    check($sformatf("v%0d exec busy", i), {31'd0, busy}, 32'd1);
    check($sformatf("v%0d alu_ctrl", i), {29'd0, alu_ctrl}, {29'd0, v.op});
    check($sformatf("v%0d alu_a", i), alu_a, v.a);
    check($sformatf("v%0d exec rsp_valid", i), {30'd0, bus.rsp_valid_1, bus.rsp_valid_0}, 32'd0);
    step();
    check($sformatf("v%0d rsp_valid", i), {30'd0, bus.rsp_valid_1, bus.rsp_valid_0},
          v.who ? 32'd2 : 32'd1);
    check($sformatf("v%0d result", i), bus.rsp_result, v.expRes);
    check($sformatf("v%0d zero", i), {31'd0, bus.rsp_zero}, {31'd0, v.expZero});
    check($sformatf("v%0d overflow", i), {31'd0, bus.rsp_overflow}, {31'd0, v.expOvf});
    if (!v.who) bus.rsp_ready_0 = 1'b1; else bus.rsp_ready_1 = 1'b1;
    step();
    bus.rsp_ready_0 = 1'b0;
    bus.rsp_ready_1 = 1'b0;
    if (!v.who) expCnt0++; else expCnt1++;
    check($sformatf("v%0d post rsp_valid", i), {30'd0, bus.rsp_valid_1, bus.rsp_valid_0}, 32'd0);
    check($sformatf("v%0d done_cnt_0", i), {16'd0, done_cnt_0}, expCnt0);
    check($sformatf("v%0d done_cnt_1", i), {16'd0, done_cnt_1}, expCnt1);
  endtask

  task automatic checkResetState(input string tag);
    check({tag, " rsp_valid"}, {30'd0, bus.rsp_valid_1, bus.rsp_valid_0}, 32'd0);
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
    check({tag, " alu_ctrl"}, {29'd0, alu_ctrl}, 32'd0);
    check({tag, " rsp_result"}, bus.rsp_result, 32'd0);
    check({tag, " done_cnt_0"}, {16'd0, done_cnt_0}, 32'd0);
    check({tag, " done_cnt_1"}, {16'd0, done_cnt_1}, 32'd0);
  endtask

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //        who  a             b             op      result        z     ovf
    vecs[0] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 3'b000, 32'h80000000, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 32'h00001234, 32'h00001234, 3'b001, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 3'b101, 32'h00000001, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'hFF00FF00, 32'h0F0F0F0F, 3'b011, 32'hF00FF00F, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h0000F0F0, 32'h00000FF0, 3'b010, 32'h000000F0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h80000000, 32'h00000001, 3'b001, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 3'b000, 32'h00000000, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 32'h12345678, 32'h00000001, 3'b111, 32'h00000000, 1'b1, 1'b0};

    clearInputs();
    bus.req_a_0 = '0; bus.req_b_0 = '0; bus.req_op_0 = '0;
    bus.req_a_1 = '0; bus.req_b_1 = '0; bus.req_op_1 = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checkResetState("reset");

    // Idle with no requests: nothing granted
    step();
    check("idle req_ready", {30'd0, bus.req_ready_1, bus.req_ready_0}, 32'd0);
    check("idle busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 8; i++) runVec(i);

    // Fairness: both valid from reset, rsp_ready tied high, 3 cycles per op
    rst = 1'b1;
    driveReq(1'b0, 32'd1, 32'd2, 3'b000);
    driveReq(1'b1, 32'd9, 32'd4, 3'b001);
    bus.rsp_ready_0 = 1'b1;
    bus.rsp_ready_1 = 1'b1;
    step();
    rst = 1'b0;
    expCnt0 = 0;
    expCnt1 = 0;
    for (int k = 0; k < 6; k++) begin
      logic w;
      w = logic'(k % 2);
      check($sformatf("fair%0d grant", k), {30'd0, bus.req_ready_1, bus.req_ready_0},
            w ? 32'd2 : 32'd1);
      step();
      check($sformatf("fair%0d exec busy", k), {31'd0, busy}, 32'd1);
      step();
      check($sformatf("fair%0d rsp_valid", k), {30'd0, bus.rsp_valid_1, bus.rsp_valid_0},
            w ? 32'd2 : 32'd1);
      check($sformatf("fair%0d result", k), bus.rsp_result, w ? 32'd5 : 32'd3);
      step();
      if (w) expCnt1++; else expCnt0++;
    end
    check("fair done_cnt_0", {16'd0, done_cnt_0}, 32'd3);
    check("fair done_cnt_1", {16'd0, done_cnt_1}, 32'd3);

    // Backpressure: requester 0 wins the tie (last grant was 1), holds 5 cycles
    clearInputs();
    driveReq(1'b0, 32'h0000F0F0, 32'h00000FF0, 3'b010);
    driveReq(1'b1, 32'd5, 32'd6, 3'b000);
    #1;
    check("bp grant", {30'd0, bus.req_ready_1, bus.req_ready_0}, 32'd1);
    step();
    bus.req_valid_0 = 1'b0;
    #1;
    check("bp exec req_ready_1", {31'd0, bus.req_ready_1}, 32'd0);
    step();
    bus.rsp_ready_1 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp%0d rsp_valid", c), {30'd0, bus.rsp_valid_1, bus.rsp_valid_0}, 32'd1);
      check($sformatf("bp%0d result", c), bus.rsp_result, 32'h000000F0);
      check($sformatf("bp%0d req_ready_1", c), {31'd0, bus.req_ready_1}, 32'd0);
      step();
    end
    bus.rsp_ready_0 = 1'b1;
    step();
    bus.rsp_ready_0 = 1'b0;
    expCnt0++;
    check("bp after rsp_valid", {30'd0, bus.rsp_valid_1, bus.rsp_valid_0}, 32'd0);
    check("bp after req_ready_1", {31'd0, bus.req_ready_1}, 32'd1);
    check("bp done_cnt_0", {16'd0, done_cnt_0}, expCnt0);
    step();
    bus.req_valid_1 = 1'b0;
    step();
    check("bp r1 rsp_valid", {30'd0, bus.rsp_valid_1, bus.rsp_valid_0}, 32'd2);
    check("bp r1 result", bus.rsp_result, 32'd11);
    step();
    expCnt1++;
    bus.rsp_ready_1 = 1'b0;
    check("bp done_cnt_1", {16'd0, done_cnt_1}, expCnt1);

    // Make requester 0 the last served so a post-reset tie proves the reset value
    runVec(4);

    // Reset mid-operation: xor from requester 1, rst in its EXEC cycle
    driveReq(1'b1, 32'h0000AAAA, 32'h00005555, 3'b011);
    step();
    bus.req_valid_1 = 1'b0;
    bus.rsp_ready_1 = 1'b1;
    #1;
    check("rstmid exec busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkResetState("rstmid");
    step();
    check("rstmid later rsp_valid", {30'd0, bus.rsp_valid_1, bus.rsp_valid_0}, 32'd0);
    bus.rsp_ready_1 = 1'b0;
    driveReq(1'b0, 32'd1, 32'd1, 3'b000);
    driveReq(1'b1, 32'd2, 32'd2, 3'b000);
    #1;
    check("rstmid tie grant", {30'd0, bus.req_ready_1, bus.req_ready_0}, 32'd1);
    clearInputs();
    step();

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester round-robin arbiter that shares a single combinational ALU (A, B, 3-bit ALUControl, Result, Zero, Overflow) between two clients.
- Each client uses a valid/ready request channel and a valid/ready response channel.
- The block latches the operands, drives the ALU for one execute cycle and registers the result and flags.
- It then holds the response until the owning client accepts it.
- It sits between the issue logic of two datapath clients and the one shared ALU instance.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must match the attached ALU.
- CNT_WIDTH, 16, width of the per-requester completed-operation counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid_0 / req_valid_1  in  1  requester has an operation pending.
- req_ready_0 / req_ready_1  out  1  request accepted this cycle; combinational.
- req_a_0 / req_a_1, req_b_0 / req_b_1  in  WIDTH  operands.
- req_op_0 / req_op_1  in  3  ALU control code (000 add, 001 sub, 010 and, 011 xor, 101 slt).
- rsp_valid_0 / rsp_valid_1  out  1  response for that requester is available.
- rsp_ready_0 / rsp_ready_1  in  1  requester takes the response.
- rsp_result  out  WIDTH  registered ALU result; shared by both requesters.
- rsp_zero, rsp_overflow  out  1  registered ALU flags.
- alu_a, alu_b  out  WIDTH  to ALU A/B.
- alu_ctrl  out  3  to ALU control input.
- alu_result  in  WIDTH  from ALU Result.
- alu_zero, alu_overflow  in  1  from ALU flags.
- busy  out  1  high in any state other than IDLE.
- done_cnt_0 / done_cnt_1  out  CNT_WIDTH  completed responses per requester.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is computed from req_valid_* and last_grant.
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester not equal to last_grant wins.
  - req_ready_<winner> = 1 that cycle.
  - On the edge: latch a, b and op into op registers, record owner, go to EXEC.
  - If neither requester is valid: stay in IDLE, both req_ready = 0.
- req_ready_* is 0 in EXEC and RESP.
- req_ready_x depends only on state, req_valid_* and last_grant. Requesters must not make req_valid depend on req_ready.
- EXEC:
  - The ALU is driven from the op registers; the ALU is purely combinational.
  - On the edge: capture alu_result, alu_zero and alu_overflow into the rsp_* registers, go to RESP.
- RESP:
  - rsp_valid_<owner> = 1 and the other rsp_valid = 0.
  - rsp_result and the flags are held stable.
  - When rsp_ready_<owner> = 1: on the edge, last_grant <= owner, done_cnt_<owner> increments, go to IDLE.
  - rsp_ready of the non-owner is ignored.
- alu_a, alu_b and alu_ctrl always reflect the op registers; in IDLE and RESP they hold their last value.
- Op codes are forwarded unchanged. Undefined codes (100, 110, 111) produce whatever the ALU returns; no error is flagged.
- done_cnt_* wraps modulo 2^CNT_WIDTH.
- Reset (synchronous, any state):
  - State goes to IDLE; any in-flight operation is dropped with no response.
  - last_grant = 1, so requester 0 wins the first tie.
  - Op registers, rsp_result, rsp_zero, rsp_overflow, done_cnt_0 and done_cnt_1 = 0.
  - Outputs after reset: rsp_valid_* = 0, busy = 0, alu_ctrl = 000.
- Reset has priority over every handshake in the same cycle.

## Timing
- Request accepted at edge N (valid & ready high in cycle N-1 … sampled at edge N).
- The EXEC cycle follows.
- rsp_valid rises after edge N+1 and is visible in the cycle before edge N+2, i.e. 2 cycles after acceptance.
- The response is held for ≥1 cycle until rsp_ready.
- With rsp_ready tied high, minimum occupancy is 3 cycles per operation and peak throughput is 1 op / 3 cycles.
- req_ready can reassert in the cycle immediately after the response handshake edge.
- The next request cannot be accepted in the same cycle as the response handshake.
- No combinational path from alu_* inputs to any output; all rsp_* outputs are registered.

## Test plan
- Single add, requester 0: a=0x7FFFFFFF, b=1, op=000.
  - Expect rsp_valid_0 two cycles after acceptance with rsp_result=0x80000000, rsp_overflow=1, rsp_zero=0.
  - Expect done_cnt_0=1 after the handshake.
- Sub to zero, requester 1: a=b=0x1234, op=001.
  - Expect rsp_result=0, rsp_zero=1, rsp_overflow=0; rsp_valid_0 stays 0 throughout.
- Fairness: both requesters hold valid continuously for 6 operations from reset, rsp_ready tied high.
  - Expect grant order 0,1,0,1,0,1; done_cnt_0 = done_cnt_1 = 3; each operation occupies 3 cycles.
- Backpressure: rsp_ready_0 held low 5 cycles after rsp_valid_0 rises (and=0xF0F0 & 0x0FF0), then high.
  - Expect rsp_result=0x00F0 stable throughout, req_ready_1=0 while waiting even with req_valid_1=1.
  - Expect requester 1 granted the cycle after the handshake.
- Reset mid-operation: assert rst in the EXEC cycle of an xor.
  - Expect no rsp_valid; outputs return to reset values next cycle.
  - Expect requester 0 wins the next tie; done counters = 0.
- slt, requester 0: a=0xFFFFFFFF (−1), b=1, op=101.
  - Expect rsp_result=1, rsp_zero=0.
